// File: rtl/slu_pkg.sv
// ============================================================================
// Module   : slu_pkg
// Purpose  : Shared address map, status/control bit positions and timer
//            state encoding for the slu bus register blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slu_pkg;

  localparam logic [7:0] c_ADDR_CARD_TYPE   = 8'h00;
  localparam logic [7:0] c_ADDR_CARD_CONFIG = 8'h01;
  localparam logic [7:0] c_ADDR_STATUS_CTRL = 8'h02;
  localparam logic [7:0] c_ADDR_SHADOW_BASE = 8'h03;

  localparam int c_STAT_BUSY_BIT    = 0;
  localparam int c_STAT_PENDING_BIT = 1;
  localparam int c_STAT_ERR_BIT     = 7;

  localparam int c_CTRL_COMMIT_BIT  = 0;
  localparam int c_CTRL_DISCARD_BIT = 1;
  localparam int c_CTRL_CLR_ERR_BIT = 7;

  localparam logic [7:0] c_RD_INVALID = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } timer_state_t;

  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic pending,
                                             input logic err);
    logic [7:0] s;
    s                     = '0;
    s[c_STAT_BUSY_BIT]    = busy;
    s[c_STAT_PENDING_BIT] = pending;
    s[c_STAT_ERR_BIT]     = err;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slu_strobe_sync.sv
// ============================================================================
// Module   : slu_strobe_sync
// Purpose  : Two-flop synchronizer plus rising-edge detector that turns an
//            asynchronous bus strobe into a single-clk access pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slu_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_strobe,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_fill;

  // r_fill marks when r_prev holds a genuinely sampled strobe, so a strobe
  // already high at reset release never looks like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fill  <= {r_fill[1:0], 1'b1};
    end
  end

  assign o_pulse = r_fill[2] & r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/slu_regbank.sv
// ============================================================================
// Module   : slu_regbank
// Purpose  : Host-visible relay register bank with shadow image, atomic
//            commit/discard and a relay settle timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slu_regbank
  import slu_pkg::*;
#(
  parameter int         NUM_BYTES     = 16,
  parameter logic [7:0] CARD_TYPE     = 8'h43,
  parameter logic [7:0] CARD_CONFIG   = 8'h0F,
  parameter int         SETTLE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rw_n,
  input  logic                   strobe,
  input  logic [7:0]             address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   data_oe,
  output logic [8*NUM_BYTES-1:0] relays,
  output logic                   busy,
  output logic                   commit_pulse
);

  localparam int                 c_CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [8:0]         c_LAST_SHADOW = 9'(2 + NUM_BYTES);

  logic [7:0]         r_shadow [NUM_BYTES];
  logic [7:0]         r_relays [NUM_BYTES];
  logic [7:0]         r_data_out;
  logic               r_err;
  logic               r_commit_pulse;
  timer_state_t       r_state;
  timer_state_t       w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic       w_access;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_byte_idx;
  logic       w_is_shadow;
  logic       w_is_ro;
  logic       w_is_ctrl;
  logic       w_addr_valid;
  logic       w_ctrl_wr;
  logic       w_commit;
  logic       w_discard;
  logic       w_shadow_wr;
  logic       w_err_set;
  logic       w_err_clr;
  logic       w_busy;
  logic       w_pending;
  logic [7:0] w_shadow_rd;
  logic [7:0] w_rd_data;

  slu_strobe_sync u_strobe_sync (
    .clk      (clk),
    .reset    (reset),
    .i_strobe (strobe),
    .o_pulse  (w_access)
  );

  assign data_oe = rw_n;

  // Address/data/direction are only meaningful during the access pulse.
  assign w_rd         = w_access & rw_n;
  assign w_wr         = w_access & ~rw_n;
  assign w_byte_idx   = address - c_ADDR_SHADOW_BASE;
  assign w_is_shadow  = (address >= c_ADDR_SHADOW_BASE) && ({1'b0, address} <= c_LAST_SHADOW);
  assign w_is_ro      = (address == c_ADDR_CARD_TYPE) || (address == c_ADDR_CARD_CONFIG);
  assign w_is_ctrl    = (address == c_ADDR_STATUS_CTRL);
  assign w_addr_valid = w_is_ro | w_is_ctrl | w_is_shadow;

  assign w_ctrl_wr   = w_wr & w_is_ctrl;
  assign w_commit    = w_ctrl_wr & data_in[c_CTRL_COMMIT_BIT];
  assign w_discard   = w_ctrl_wr & data_in[c_CTRL_DISCARD_BIT] & ~data_in[c_CTRL_COMMIT_BIT];
  assign w_shadow_wr = w_wr & w_is_shadow;
  assign w_err_set   = (w_rd & ~w_addr_valid) | (w_wr & (w_is_ro | ~w_addr_valid));
  assign w_err_clr   = w_ctrl_wr & data_in[c_CTRL_CLR_ERR_BIT];

  assign w_busy = (r_cnt != '0);

  always_comb begin
    w_shadow_rd = '0;
    w_pending   = 1'b0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (w_byte_idx == 8'(k)) w_shadow_rd = r_shadow[k];
      if (r_shadow[k] != r_relays[k]) w_pending = 1'b1;
    end
  end

  always_comb begin
    w_rd_data = c_RD_INVALID;
    if (address == c_ADDR_CARD_TYPE)        w_rd_data = CARD_TYPE;
    else if (address == c_ADDR_CARD_CONFIG) w_rd_data = CARD_CONFIG;
    else if (w_is_ctrl)                     w_rd_data = status_byte(w_busy, w_pending, r_err);
    else if (w_is_shadow)                   w_rd_data = w_shadow_rd;
  end

  // Commit and discard are whole-image copies; a byte write never coincides
  // with either because each access addresses exactly one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        r_shadow[k] <= '0;
        r_relays[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (w_commit)
          r_relays[k] <= r_shadow[k];
        else if (w_discard)
          r_shadow[k] <= r_relays[k];
        if (w_shadow_wr && (w_byte_idx == 8'(k)))
          r_shadow[k] <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out     <= '0;
      r_err          <= 1'b0;
      r_commit_pulse <= 1'b0;
    end else begin
      r_commit_pulse <= w_commit;
      if (w_rd) r_data_out <= w_rd_data;
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_commit) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = c_SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (w_commit) begin
          w_cnt_nxt = c_SETTLE_LOAD;
        end else if ((r_cnt == c_CNT_ONE) || (r_cnt == '0)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
    endcase
  end

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_relay_out
    assign relays[8*k +: 8] = r_relays[k];
  end

  assign data_out     = r_data_out;
  assign busy         = w_busy;
  assign commit_pulse = r_commit_pulse;

endmodule

`default_nettype wire

// File: tb/tb_slu_regbank.sv
// ============================================================================
// Module   : tb_slu_regbank
// Purpose  : Directed self-checking bench for slu_regbank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slu_regbank;

  localparam int NB = 4;
  localparam int SC = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            rw_n;
  logic            strobe;
  logic [7:0]      address;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic            data_oe;
  logic [8*NB-1:0] relays;
  logic            busy;
  logic            commit_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  slu_regbank #(
    .NUM_BYTES     (NB),
    .CARD_TYPE     (8'h43),
    .CARD_CONFIG   (8'h0F),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rw_n         (rw_n),
    .strobe       (strobe),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .relays       (relays),
    .busy         (busy),
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (commit_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic bus_start(input logic rw, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rw_n    = rw;
    address = a;
    data_in = d;
    strobe  = 1'b1;
  endtask

  task automatic bus_drop();
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_start(1'b0, a, d);
    repeat (6) @(negedge clk);
    bus_drop();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_start(1'b1, a, 8'h00);
    repeat (6) @(negedge clk);
    d = data_out;
    bus_drop();
  endtask

  task automatic wait_pulse(input int c0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt != c0) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      $display("FAIL commit_pulse_timeout: got no pulse, required one within 50 clk");
      fails++;
    end
  endtask

  task automatic wait_busy_low(output int fall);
    bit seen;
    seen = 1'b0;
    fall = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) begin
        seen = 1'b1;
        fall = cyc;
      end
    end
    tests++;
    if (!seen) begin
      $display("FAIL busy_timeout: busy still %b, required 0 within 200 clk", busy);
      fails++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    // Strobe is already high (a write to 0x00) when reset releases.
    reset = 1'b1; strobe = 1'b1; rw_n = 1'b0; address = 8'h00; data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (data_out !== 8'h00 || busy !== 1'b0 || commit_pulse !== 1'b0 || relays !== '0) begin
      $display("FAIL reset_state: data_out=%h busy=%b pulse=%b relays=%h required 00 0 0 0",
               data_out, busy, commit_pulse, relays);
      fails++;
    end
    tests++;
    if (data_oe !== 1'b0) begin
      $display("FAIL data_oe_low: got %b required 0", data_oe);
      fails++;
    end
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h00) begin
      $display("FAIL no_access_after_reset: status=%h required 00", d);
      fails++;
    end
  endtask

  task automatic test_id_regs();
    logic [7:0] d;
    bus_read(8'h00, d);
    tests++;
    if (d !== 8'h43) begin
      $display("FAIL card_type: got %h required 43", d);
      fails++;
    end
    tests++;
    if (data_oe !== 1'b1) begin
      $display("FAIL data_oe_high: got %b required 1", data_oe);
      fails++;
    end
    bus_read(8'h01, d);
    tests++;
    if (d !== 8'h0F) begin
      $display("FAIL card_config: got %h required 0F", d);
      fails++;
    end
  endtask

  task automatic test_shadow_write();
    logic [7:0] d;
    bus_write(8'h03, 8'hA5);
    bus_read(8'h03, d);
    tests++;
    if (d !== 8'hA5) begin
      $display("FAIL shadow0_readback: got %h required A5", d);
      fails++;
    end
    tests++;
    if (relays !== '0) begin
      $display("FAIL relays_untouched: got %h required 00000000", relays);
      fails++;
    end
    bus_write(8'h06, 8'h3C);
    bus_read(8'h06, d);
    tests++;
    if (d !== 8'h3C) begin
      $display("FAIL shadow_last_readback: got %h required 3C", d);
      fails++;
    end
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h02) begin
      $display("FAIL status_pending: got %h required 02", d);
      fails++;
    end
  endtask

  task automatic test_commit();
    logic [7:0] d;
    bit ok;
    int c0, p1, fall;
    c0 = pulse_cnt;
    bus_start(1'b0, 8'h02, 8'h01);
    wait_pulse(c0, ok);
    p1 = last_pulse_cyc;
    tests++;
    if (relays !== 32'h3C0000A5) begin
      $display("FAIL commit_relays: got %h required 3C0000A5", relays);
      fails++;
    end
    bus_drop();
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h01) begin
      $display("FAIL status_settling: got %h required 01", d);
      fails++;
    end
    wait_busy_low(fall);
    tests++;
    if (fall - p1 != SC) begin
      $display("FAIL busy_duration: got %0d clk required %0d", fall - p1, SC);
      fails++;
    end
    tests++;
    if (pulse_cnt - c0 != 1) begin
      $display("FAIL commit_pulse_count: got %0d required 1", pulse_cnt - c0);
      fails++;
    end
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h00) begin
      $display("FAIL status_settled: got %h required 00", d);
      fails++;
    end
  endtask

  task automatic test_commit_restart();
    bit ok;
    int c0, c1, p1, p2, fall;
    c0 = pulse_cnt;
    bus_start(1'b0, 8'h02, 8'h01);
    wait_pulse(c0, ok);
    p1 = last_pulse_cyc;
    bus_drop();
    for (int i = 0; i < 100 && cyc < p1 + SC / 2; i++) @(negedge clk);
    c1 = pulse_cnt;
    bus_start(1'b0, 8'h02, 8'h01);
    wait_pulse(c1, ok);
    p2 = last_pulse_cyc;
    bus_drop();
    wait_busy_low(fall);
    tests++;
    if (fall - p2 != SC) begin
      $display("FAIL restart_duration: got %0d clk after 2nd pulse required %0d", fall - p2, SC);
      fails++;
    end
  endtask

  task automatic test_errors();
    logic [7:0] d;
    bus_write(8'h00, 8'h55);
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h80) begin
      $display("FAIL err_ro_write: status=%h required 80", d);
      fails++;
    end
    bus_read(8'h00, d);
    tests++;
    if (d !== 8'h43) begin
      $display("FAIL ro_write_ignored: got %h required 43", d);
      fails++;
    end
    bus_write(8'h02, 8'h80);
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h00) begin
      $display("FAIL err_clear: status=%h required 00", d);
      fails++;
    end
    bus_read(8'hFF, d);
    tests++;
    if (d !== 8'hFF) begin
      $display("FAIL invalid_read_ff: got %h required FF", d);
      fails++;
    end
    bus_write(8'h02, 8'h80);
    bus_read(8'h07, d);
    tests++;
    if (d !== 8'hFF) begin
      $display("FAIL first_beyond_map: got %h required FF", d);
      fails++;
    end
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h80) begin
      $display("FAIL err_invalid_read: status=%h required 80", d);
      fails++;
    end
    bus_write(8'h02, 8'h80);
  endtask

  task automatic test_discard();
    logic [7:0] d;
    int c0;
    bus_write(8'h03, 8'h77);
    c0 = pulse_cnt;
    bus_write(8'h02, 8'h02);
    bus_read(8'h03, d);
    tests++;
    if (d !== 8'hA5) begin
      $display("FAIL discard_restore: got %h required A5", d);
      fails++;
    end
    bus_read(8'h02, d);
    tests++;
    if (d !== 8'h00 || pulse_cnt != c0) begin
      $display("FAIL discard_status: status=%h pulses=%0d required 00 0", d, pulse_cnt - c0);
      fails++;
    end
  endtask

  task automatic test_commit_discard_reset();
    logic [7:0] d;
    bit ok;
    int c0;
    bus_write(8'h04, 8'h5A);
    c0 = pulse_cnt;
    bus_start(1'b0, 8'h02, 8'h03);
    wait_pulse(c0, ok);
    tests++;
    if (relays !== 32'h3C005AA5) begin
      $display("FAIL commit_wins: relays=%h required 3C005AA5", relays);
      fails++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || relays !== '0 || commit_pulse !== 1'b0) begin
      $display("FAIL reset_mid_settle: busy=%b relays=%h pulse=%b required 0 0 0",
               busy, relays, commit_pulse);
      fails++;
    end
    strobe = 1'b0;
    reset  = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8'h04, d);
    tests++;
    if (d !== 8'h00) begin
      $display("FAIL shadow_reset: got %h required 00", d);
      fails++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_id_regs();
    test_shadow_write();
    test_commit();
    test_commit_restart();
    test_errors();
    test_discard();
    test_commit_discard_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slu_regbank.md
SLU_REGBANK -- requirements
Module: slu_regbank

Interface
REQ-001 Parameter NUM_BYTES, default 16: number of relay bytes; legal range 1..253.
REQ-002 Parameter CARD_TYPE, default 8'h43: value returned at address 0x00.
REQ-003 Parameter CARD_CONFIG, default 8'h0F: value returned at address 0x01.
REQ-004 Parameter SETTLE_CYCLES, default 1000: relay settle time in clk cycles after a commit; minimum 1.
REQ-005 Port clk  input  1  single system clock; all state is clocked on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port rw_n  input  1  bus direction; high = host reads from FPGA, low = host writes to FPGA.
REQ-008 Port strobe  input  1  bus strobe, asynchronous to clk; the access executes on its rising edge.
REQ-009 Port address  input  8  bus byte address.
REQ-010 Port data_in  input  8  bus write data.
REQ-011 Port data_out  output  8  bus read data.
REQ-012 Port data_oe  output  1  top-level tristate enable for the data bus.
REQ-013 Port relays  output  8*NUM_BYTES  active relay image; byte k occupies bits [8k+7:8k].
REQ-014 Port busy  output  1  high while the settle timer runs.
REQ-015 Port commit_pulse  output  1  one-clk pulse when the shadow image is copied to relays.

Function
REQ-016 strobe SHALL pass through a 2-flop synchronizer; a 0->1 transition at the synchronizer output produces one access-pulse of one clk.
REQ-017 address, data_in and rw_n SHALL be sampled in the access-pulse cycle; the host holds them stable for at least 4 clk after the strobe rise.
REQ-018 data_oe SHALL equal rw_n combinationally.
REQ-019 Address map: 0x00 CARD_TYPE (read-only), 0x01 CARD_CONFIG (read-only), 0x02 status/control, 0x03..0x02+NUM_BYTES shadow relay bytes (read/write); all other addresses are invalid.
REQ-020 A read SHALL update data_out on the clk after the access-pulse; data_out holds until the next read.
REQ-021 Status read: bit0 = busy; bit1 = pending (shadow differs from relays); bit7 = err; bits 6..2 = 0.
REQ-022 A read of the shadow bytes SHALL return shadow contents, not relays.
REQ-023 A read of an invalid address SHALL return 8'hFF and set err.
REQ-024 A write to a shadow byte SHALL update only that byte on the clk after the access-pulse; relays are unchanged.
REQ-025 Writes to 0x00, 0x01 or invalid addresses SHALL be ignored and set err.
REQ-026 Control write: bit0 = commit, bit1 = discard, bit7 = clear err; other bits are ignored.
REQ-027 Commit SHALL copy the whole shadow to relays in one clk, pulse commit_pulse, and load the settle counter with SETTLE_CYCLES.
REQ-028 busy SHALL be high while the counter is nonzero; the counter decrements once per clk; busy falls exactly SETTLE_CYCLES clk after commit_pulse.
REQ-029 A commit while busy SHALL be accepted and SHALL restart the counter at SETTLE_CYCLES.
REQ-030 Discard SHALL copy relays to shadow in one clk; busy is unaffected.
REQ-031 Commit and discard in the same write: commit wins and discard is ignored.
REQ-032 Clear-err together with an error-causing event in the same cycle: the set wins.
REQ-033 Timer FSM states: IDLE (counter=0) and SETTLE; IDLE->SETTLE on commit; SETTLE->SETTLE on commit (reload); SETTLE->IDLE when the counter reaches 0.

Reset
REQ-034 On reset: shadow and relays = 0; counter = 0; FSM = IDLE; busy = 0; commit_pulse = 0; err = 0; data_out = 8'h00; synchronizer flops = 0.
REQ-035 Reset mid-settle or mid-access SHALL abort it; no access-pulse SHALL be generated from a strobe already high when reset releases.

Structure
REQ-036 Address constants (0x00..0x03), status/control bit positions and the invalid-read value 8'hFF SHALL live in the shared package slu_pkg.
REQ-037 The synchronizer plus edge detector SHALL be one sub-module, slu_strobe_sync, reusable by other bus blocks.
REQ-038 The data bus tristate SHALL reside in the top level, not in this block.

Verification
REQ-039 Reset, then read 0x00 and 0x01 -> data_out = 0x43, then 0x0F; data_oe follows rw_n.
REQ-040 Write 0xA5 to 0x03 -> read 0x03 = 0xA5; relays[7:0] = 0; status = 0x02.
REQ-041 Write 0x01 to 0x02 -> relays[7:0] = 0xA5; one commit_pulse; busy high for exactly SETTLE_CYCLES clk; status = 0x01 during settle, then 0x00.
REQ-042 Commit at SETTLE_CYCLES/2 -> busy extends to SETTLE_CYCLES after the second commit_pulse.
REQ-043 Write to 0x00 and read 0xFF (address beyond the map) -> read returns 0xFF; status bit7 = 1; write 0x80 to 0x02 clears it.
REQ-044 Write 0x03 to 0x02 (commit+discard) -> commit occurs; assert reset mid-settle -> busy = 0 and relays = 0 next clk.
